// File: rtl/ysyx_mem_arbiter.sv
// IFU/LSU arbiter onto a single-outstanding downstream memory bus.
// Optional response timeout: define YSYX_MEM_ARBITER_TIMEOUT_EN.

module ysyx_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_rvalid,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  input  logic [7:0]        lsu_rstrb,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_rvalid,
  input  logic [ADDR_W-1:0] lsu_awaddr,
  input  logic              lsu_awvalid,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  input  logic              lsu_wvalid,
  output logic              lsu_wready,
  output logic [ADDR_W-1:0] bus_araddr,
  output logic              bus_arvalid,
  output logic [7:0]        bus_rstrb,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid,
  output logic [ADDR_W-1:0] bus_awaddr,
  output logic              bus_awvalid,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [7:0]        bus_wstrb,
  output logic              bus_wvalid,
  input  logic              bus_wready,
  output logic              bus_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    RD_IFU,
    RD_LSU,
    WR_LSU
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_last_lsu;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_strb;

  logic w_store;
  logic w_lsu_req;
  logic w_g_ifu;
  logic w_g_st;
  logic w_g_ld;
  logic w_rd_ifu;
  logic w_rd_lsu;
  logic w_wr;
  logic w_rd;
  logic w_rsp;
  logic w_tmo;
  logic w_done;

  assign w_store   = lsu_awvalid & lsu_wvalid;
  assign w_lsu_req = w_store | lsu_arvalid;

  // IFU wins a tie only when LSU held the previous grant
  assign w_g_ifu = ifu_arvalid & (~w_lsu_req | r_last_lsu);
  assign w_g_st  = ~w_g_ifu & w_store;
  assign w_g_ld  = ~w_g_ifu & ~w_store & lsu_arvalid;

  assign w_rd_ifu = (r_state == RD_IFU);
  assign w_rd_lsu = (r_state == RD_LSU);
  assign w_wr     = (r_state == WR_LSU);
  assign w_rd     = w_rd_ifu | w_rd_lsu;

  assign w_rsp  = (w_rd & bus_rvalid) | (w_wr & bus_wready);
  assign w_done = w_rsp | w_tmo;

`ifdef YSYX_MEM_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // a real response on the limit cycle beats the timeout
  assign w_tmo = (r_state != IDLE) & (r_cnt == LIM) & ~w_rsp;
`else
  logic w_unused_tc;
  assign w_unused_tc = (TIMEOUT_CYCLES != 0);
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        unique case (1'b1)
          w_g_ifu: w_next = RD_IFU;
          w_g_st:  w_next = WR_LSU;
          w_g_ld:  w_next = RD_LSU;
          default: w_next = IDLE;
        endcase
      end
      default: begin
        if (w_done) w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_lsu <= 1'b1;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_strb     <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        unique case (1'b1)
          w_g_ifu: begin
            r_addr     <= ifu_araddr;
            r_strb     <= 8'hf;
            r_last_lsu <= 1'b0;
          end
          w_g_st: begin
            r_addr     <= lsu_awaddr;
            r_wdata    <= lsu_wdata;
            r_strb     <= lsu_wstrb;
            r_last_lsu <= 1'b1;
          end
          w_g_ld: begin
            r_addr     <= lsu_araddr;
            r_strb     <= lsu_rstrb;
            r_last_lsu <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // everything is forced low while rst_n is held
  assign bus_arvalid = rst_n & w_rd;
  assign bus_araddr  = bus_arvalid ? r_addr : '0;
  assign bus_rstrb   = bus_arvalid ? r_strb : 8'h0;

  assign bus_awvalid = rst_n & w_wr;
  assign bus_wvalid  = bus_awvalid;
  assign bus_awaddr  = bus_awvalid ? r_addr : '0;
  assign bus_wdata   = bus_awvalid ? r_wdata : '0;
  assign bus_wstrb   = bus_awvalid ? r_strb : 8'h0;

  assign ifu_rvalid = rst_n & w_rd_ifu & w_done;
  assign ifu_rdata  = (rst_n & w_rd_ifu & bus_rvalid) ? bus_rdata : '0;
  assign lsu_rvalid = rst_n & w_rd_lsu & w_done;
  assign lsu_rdata  = (rst_n & w_rd_lsu & bus_rvalid) ? bus_rdata : '0;
  assign lsu_wready = rst_n & w_wr & w_done;
  assign bus_err_o  = rst_n & w_tmo;

endmodule
